// File: rtl/screen_sequencer_pkg.sv
// Shared definitions for the screen sequencing blocks: state encoding, pixel width and
// legal ranges of the timing parameters.
package screen_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_GAME  = 2'd1,
    ST_FLASH = 2'd2,
    ST_HOLD  = 2'd3
  } screen_state_e;

  localparam int unsigned RGB_W = 3;

  localparam int unsigned FLASH_FRAMES_MIN = 1;
  localparam int unsigned FLASH_FRAMES_MAX = 255;
  localparam int unsigned FLASH_COUNT_MIN  = 1;
  localparam int unsigned FLASH_COUNT_MAX  = 15;
  localparam int unsigned HOLD_FRAMES_MIN  = 1;
  localparam int unsigned HOLD_FRAMES_MAX  = 255;

endpackage

// File: rtl/frame_tick_gen.sv
// Vsync falling-edge detector. The same register stage that detects the edge also delays
// the sync lines by one cycle so they stay aligned with a registered pixel path.
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic hsync_in,
  input  logic vsync_in,
  output logic frame_tick,
  output logic hsync_dly,
  output logic vsync_dly
);

  logic hsync_q;
  logic vsync_q;

  // One-cycle sync delay; syncs are active-low so they idle high in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      hsync_q <= hsync_in;
      vsync_q <= vsync_in;
    end
  end

  // Previous Vsync high, current low: start of the vertical sync pulse.
  assign frame_tick = vsync_q & ~vsync_in;
  assign hsync_dly  = hsync_q;
  assign vsync_dly  = vsync_q;

endmodule

// File: rtl/screen_sequencer.sv
// Frame-synchronous screen selector: START -> GAME -> FLASH -> HOLD -> START.
// Requests are latched as pending flags and only committed on a frame tick, so the
// visible image never changes mid-frame.
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int unsigned FLASH_FRAMES = 30,
  parameter int unsigned FLASH_COUNT  = 3,
  parameter int unsigned HOLD_FRAMES  = 120
) (
  input  logic             CLK_40M,
  input  logic             RSTn,
  input  logic             start_key,
  input  logic             game_over_sig,
  input  logic             Hsync_in,
  input  logic             Vsync_in,
  input  logic [RGB_W-1:0] start_rgb,
  input  logic [RGB_W-1:0] game_rgb,
  input  logic [RGB_W-1:0] end_rgb,
  output logic             Vga_red,
  output logic             Vga_green,
  output logic             Vga_blue,
  output logic             Hsync_sig,
  output logic             Vsync_sig,
  output logic             game_rst_pulse,
  output logic             Flash_over_sig,
  output logic [1:0]       screen_mode
);

  screen_state_e    state_q;
  logic [7:0]       frm_cnt;
  logic [3:0]       blink_cnt;
  logic [3:0]       blink_nxt;
  logic             phase_on;
  logic             pend_start;
  logic             pend_over;
  logic             go_q;
  logic             go_rise;
  logic             frame_tick;
  logic [RGB_W-1:0] rgb_q;

  frame_tick_gen u_frame_tick_gen (
    .clk        (CLK_40M),
    .rst_n      (RSTn),
    .hsync_in   (Hsync_in),
    .vsync_in   (Vsync_in),
    .frame_tick (frame_tick),
    .hsync_dly  (Hsync_sig),
    .vsync_dly  (Vsync_sig)
  );

  assign go_rise   = game_over_sig & ~go_q;
  assign blink_nxt = blink_cnt + 4'd1;

  // Sequencer: request latching, frame-aligned state changes, counters and pulses.
  always_ff @(posedge CLK_40M or negedge RSTn) begin
    if (!RSTn) begin
      state_q        <= ST_START;
      frm_cnt        <= 8'd0;
      blink_cnt      <= 4'd0;
      phase_on       <= 1'b0;
      pend_start     <= 1'b0;
      pend_over      <= 1'b0;
      go_q           <= 1'b0;
      game_rst_pulse <= 1'b0;
      Flash_over_sig <= 1'b0;
    end else begin
      go_q           <= game_over_sig;
      game_rst_pulse <= 1'b0;
      Flash_over_sig <= 1'b0;

      // Only the request legal in the current state is latched; others are dropped.
      if (start_key && (state_q == ST_START || state_q == ST_HOLD)) pend_start <= 1'b1;
      if (go_rise && state_q == ST_GAME) pend_over <= 1'b1;

      // Commits below override the latching above, so a flag clears as it is consumed.
      if (frame_tick) begin
        unique case (state_q)
          ST_START: begin
            if (pend_start) begin
              state_q        <= ST_GAME;
              pend_start     <= 1'b0;
              game_rst_pulse <= 1'b1;
            end
          end
          ST_GAME: begin
            if (pend_over) begin
              state_q   <= ST_FLASH;
              pend_over <= 1'b0;
              frm_cnt   <= 8'd0;
              blink_cnt <= 4'd0;
              phase_on  <= 1'b1;
            end
          end
          ST_FLASH: begin
            if (frm_cnt == 8'(FLASH_FRAMES - 1)) begin
              frm_cnt <= 8'd0;
              if (!phase_on && blink_nxt == 4'(FLASH_COUNT)) begin
                state_q        <= ST_HOLD;
                Flash_over_sig <= 1'b1;
                phase_on       <= 1'b1;
              end else begin
                if (!phase_on) blink_cnt <= blink_nxt;
                phase_on <= ~phase_on;
              end
            end else begin
              frm_cnt <= frm_cnt + 8'd1;
            end
          end
          ST_HOLD: begin
            if (pend_start) begin
              state_q        <= ST_GAME;
              pend_start     <= 1'b0;
              game_rst_pulse <= 1'b1;
            end else if (frm_cnt == 8'(HOLD_FRAMES - 1)) begin
              state_q <= ST_START;
              frm_cnt <= 8'd0;
            end else begin
              frm_cnt <= frm_cnt + 8'd1;
            end
          end
        endcase
      end
    end
  end

  // Registered pixel mux; blanked during the off half of each blink.
  always_ff @(posedge CLK_40M or negedge RSTn) begin
    if (!RSTn) begin
      rgb_q <= '0;
    end else begin
      unique case (state_q)
        ST_START: rgb_q <= start_rgb;
        ST_GAME:  rgb_q <= game_rgb;
        ST_FLASH: rgb_q <= phase_on ? end_rgb : '0;
        ST_HOLD:  rgb_q <= end_rgb;
      endcase
    end
  end

  assign Vga_red     = rgb_q[2];
  assign Vga_green   = rgb_q[1];
  assign Vga_blue    = rgb_q[0];
  assign screen_mode = state_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with 100-cycle synthetic frames.
// Inputs change on the falling clock edge; outputs are sampled there too.
module tb_screen_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_key;
  logic       game_over_sig;
  logic       hsync_in;
  logic       vsync_in;
  logic [2:0] start_rgb;
  logic [2:0] game_rgb;
  logic [2:0] end_rgb;
  logic       vga_red;
  logic       vga_green;
  logic       vga_blue;
  logic       hsync_sig;
  logic       vsync_sig;
  logic       game_rst_pulse;
  logic       flash_over_sig;
  logic [1:0] screen_mode;
  logic [2:0] pins;

  int cyc;
  int n_tests;
  int n_fail;
  int n_rst;
  int n_flash;

  always #5 clk = ~clk;

  assign pins = {vga_red, vga_green, vga_blue};

  screen_sequencer #(
    .FLASH_FRAMES (2),
    .FLASH_COUNT  (2),
    .HOLD_FRAMES  (3)
  ) dut (
    .CLK_40M        (clk),
    .RSTn           (rst_n),
    .start_key      (start_key),
    .game_over_sig  (game_over_sig),
    .Hsync_in       (hsync_in),
    .Vsync_in       (vsync_in),
    .start_rgb      (start_rgb),
    .game_rgb       (game_rgb),
    .end_rgb        (end_rgb),
    .Vga_red        (vga_red),
    .Vga_green      (vga_green),
    .Vga_blue       (vga_blue),
    .Hsync_sig      (hsync_sig),
    .Vsync_sig      (vsync_sig),
    .game_rst_pulse (game_rst_pulse),
    .Flash_over_sig (flash_over_sig),
    .screen_mode    (screen_mode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one cycle: regenerate syncs from the cycle count and tally output pulses.
  task automatic step();
    @(negedge clk);
    cyc++;
    vsync_in = ((cyc % 100) >= 4);
    hsync_in = ((cyc % 20) >= 3);
    if (game_rst_pulse === 1'b1) n_rst++;
    if (flash_over_sig === 1'b1) n_flash++;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic pulse_start();
    start_key = 1'b1;
    step();
    start_key = 1'b0;
  endtask

  initial begin
    cyc = 50; n_tests = 0; n_fail = 0; n_rst = 0; n_flash = 0;
    rst_n = 1'b0; start_key = 1'b0; game_over_sig = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    start_rgb = 3'b001; game_rgb = 3'b010; end_rgb = 3'b100;

    // Reset state
    go_to(52);
    chk("rst_mode", 32'(screen_mode), 32'd0);
    chk("rst_pins", 32'(pins), 32'd0);
    chk("rst_hs", 32'(hsync_sig), 32'd1);
    chk("rst_vs", 32'(vsync_sig), 32'd1);
    chk("rst_pulses", 32'({game_rst_pulse, flash_over_sig}), 32'd0);
    go_to(53);
    rst_n = 1'b1;

    // START idle, pixel latency and sync delay
    go_to(56);
    chk("start_mode", 32'(screen_mode), 32'd0);
    chk("start_pins", 32'(pins), 32'b001);
    go_to(60);
    start_rgb = 3'b011;
    go_to(61);
    chk("lat_new", 32'(pins), 32'b011);
    start_rgb = 3'b001;
    go_to(62);
    chk("lat_restore", 32'(pins), 32'b001);
    go_to(63);
    chk("hs_dly_lo", 32'(hsync_sig), 32'd0);
    go_to(64);
    chk("hs_dly_hi", 32'(hsync_sig), 32'd1);
    go_to(101);
    chk("vs_dly_lo", 32'(vsync_sig), 32'd0);
    chk("no_key_mode", 32'(screen_mode), 32'd0);
    go_to(105);
    chk("vs_dly_hi", 32'(vsync_sig), 32'd1);

    // start_key mid-frame waits for the next frame tick
    go_to(150);
    pulse_start();
    chk("key_wait1", 32'(screen_mode), 32'd0);
    go_to(199);
    chk("key_wait2", 32'(screen_mode), 32'd0);
    go_to(201);
    chk("game_mode", 32'(screen_mode), 32'd1);
    chk("game_rst_hi", 32'(game_rst_pulse), 32'd1);
    go_to(202);
    chk("game_rst_lo", 32'(game_rst_pulse), 32'd0);
    chk("game_pins", 32'(pins), 32'b010);

    // start_key in GAME ignored; game over commits at next tick
    go_to(210);
    pulse_start();
    go_to(250);
    game_over_sig = 1'b1;
    go_to(299);
    chk("over_wait", 32'(screen_mode), 32'd1);
    go_to(301);
    chk("flash_mode", 32'(screen_mode), 32'd2);
    go_to(302);
    chk("fl_on0", 32'(pins), 32'b100);
    go_to(450);
    chk("fl_on1", 32'(pins), 32'b100);
    go_to(520);
    game_over_sig = 1'b0;
    go_to(530);
    game_over_sig = 1'b1;
    go_to(550);
    chk("fl_off0", 32'(pins), 32'b000);
    go_to(650);
    chk("fl_off1", 32'(pins), 32'b000);
    go_to(750);
    chk("fl_on2", 32'(pins), 32'b100);
    go_to(850);
    chk("fl_on3", 32'(pins), 32'b100);
    go_to(950);
    chk("fl_off2", 32'(pins), 32'b000);
    go_to(1099);
    chk("fl_off3_mode", 32'(screen_mode), 32'd2);
    chk("fl_off3_pins", 32'(pins), 32'b000);
    go_to(1101);
    chk("hold_mode", 32'(screen_mode), 32'd3);
    chk("flash_over_hi", 32'(flash_over_sig), 32'd1);
    go_to(1102);
    chk("flash_over_lo", 32'(flash_over_sig), 32'd0);
    chk("hold_pins", 32'(pins), 32'b100);
    chk("flash_over_cnt1", 32'(n_flash), 32'd1);

    // HOLD timeout after three ticks
    go_to(1301);
    chk("hold_t2", 32'(screen_mode), 32'd3);
    go_to(1401);
    chk("hold_timeout", 32'(screen_mode), 32'd0);
    go_to(1402);
    chk("back_start_pins", 32'(pins), 32'b001);

    // game_over rise in START ignored; must not leak into the next GAME
    go_to(1420);
    game_over_sig = 1'b0;
    go_to(1430);
    game_over_sig = 1'b1;
    go_to(1450);
    pulse_start();
    go_to(1501);
    chk("game2_mode", 32'(screen_mode), 32'd1);
    go_to(1510);
    game_over_sig = 1'b0;
    go_to(1601);
    chk("game2_stays", 32'(screen_mode), 32'd1);
    go_to(1650);
    game_over_sig = 1'b1;
    go_to(1701);
    chk("flash2_mode", 32'(screen_mode), 32'd2);
    go_to(1950);
    chk("fl2_off0", 32'(pins), 32'b000);
    game_over_sig = 1'b0;
    go_to(1970);
    game_over_sig = 1'b1;
    go_to(2150);
    chk("fl2_on1", 32'(pins), 32'b100);
    go_to(2350);
    chk("fl2_off1", 32'(pins), 32'b000);
    go_to(2501);
    chk("hold2_mode", 32'(screen_mode), 32'd3);
    chk("flash_over_cnt2", 32'(n_flash), 32'd2);

    // Restart from HOLD frame 2, straight to GAME
    go_to(2650);
    pulse_start();
    go_to(2699);
    chk("restart_wait", 32'(screen_mode), 32'd3);
    go_to(2701);
    chk("restart_mode", 32'(screen_mode), 32'd1);
    chk("rst_pulse_cnt", 32'(n_rst), 32'd3);
    go_to(2702);
    chk("restart_pins", 32'(pins), 32'b010);
    go_to(2801);
    chk("game3_stays", 32'(screen_mode), 32'd1);

    // Reset during the FLASH off phase
    go_to(2810);
    game_over_sig = 1'b0;
    go_to(2850);
    game_over_sig = 1'b1;
    go_to(2901);
    chk("flash3_mode", 32'(screen_mode), 32'd2);
    go_to(3150);
    chk("fl3_off", 32'(pins), 32'b000);
    rst_n = 1'b0;
    #1;
    chk("async_mode", 32'(screen_mode), 32'd0);
    chk("async_pins", 32'(pins), 32'd0);
    chk("async_sync", 32'({hsync_sig, vsync_sig}), 32'b11);
    go_to(3153);
    rst_n = 1'b1;
    go_to(3155);
    chk("post_rst_mode", 32'(screen_mode), 32'd0);
    chk("post_rst_pins", 32'(pins), 32'b001);
    go_to(3801);
    chk("post_rst_idle", 32'(screen_mode), 32'd0);
    chk("no_flash_over", 32'(n_flash), 32'd2);
    chk("no_game_rst", 32'(n_rst), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
Frame-synchronous controller that decides which screen image source (start screen, game playfield, game-over screen) drives the shared VGA pins.
- Sits between the shared VGA sync generator, the three pixel sources and the board pins.
- Sequences START -> GAME -> FLASH -> HOLD -> START.
- Commits every screen switch only on a frame boundary.
- Blinks the game-over image a fixed number of times, then holds it.

Parameters:
FLASH_FRAMES, 30, frames per blink half-period (image on, then image off); range 1..255
FLASH_COUNT, 3, number of on/off blink cycles before HOLD; range 1..15
HOLD_FRAMES, 120, frames the game-over image stays steady before returning to START; range 1..255

Ports:
CLK_40M  input  1  pixel clock, 40 MHz
RSTn  input  1  asynchronous, active-low reset
start_key  input  1  single-cycle pulse, already debounced upstream
game_over_sig  input  1  level from game logic; its rising edge requests game over
Hsync_in  input  1  active-low horizontal sync from the shared sync generator
Vsync_in  input  1  active-low vertical sync from the shared sync generator
start_rgb  input  3  {r,g,b} from the start-screen source, already blank-gated
game_rgb  input  3  {r,g,b} from the game renderer
end_rgb  input  3  {r,g,b} from the game-over image source
Vga_red, Vga_green, Vga_blue  output  1 each  selected pixel, registered
Hsync_sig, Vsync_sig  output  1 each  sync inputs delayed 1 cycle to stay aligned with the pixel
game_rst_pulse  output  1  1-cycle pulse on entry to GAME
Flash_over_sig  output  1  1-cycle pulse on the FLASH->HOLD transition
screen_mode  output  2  0=START, 1=GAME, 2=FLASH, 3=HOLD

Behaviour:
- Reset values (RSTn low, asynchronous): state START, all counters 0, pending flags 0, rgb outputs 0, Hsync_sig/Vsync_sig 1, pulse outputs 0, screen_mode 0.
- frame_tick: Vsync_in registered once; tick when the previous value is 1 and the current value is 0. One tick per frame.
- Request latching:
  - start_key sets pend_start, only in START or HOLD.
  - A rising edge of game_over_sig sets pend_over, only in GAME.
  - All other requests are ignored and never queued.
  - Pending flags clear on the cycle the transition commits.
- START: on frame_tick with pend_start -> GAME. Assert game_rst_pulse in the same cycle that screen_mode becomes 1.
- GAME: on frame_tick with pend_over -> FLASH. Clear frm_cnt and blink_cnt; blink phase = on.
- FLASH, evaluated on each frame_tick:
  - frm_cnt increments.
  - When frm_cnt reaches FLASH_FRAMES-1: frm_cnt -> 0 and the phase toggles.
  - On the off->on toggle, blink_cnt increments.
  - When blink_cnt reaches FLASH_COUNT on that toggle: go to HOLD, pulse Flash_over_sig, clear frm_cnt.
- HOLD, on frame_tick:
  - pend_start -> GAME (restart).
  - Otherwise frm_cnt increments.
  - When frm_cnt reaches HOLD_FRAMES-1 -> START.
  - If restart and timeout coincide, restart wins.
- Output mux:
  - START: start_rgb. GAME: game_rgb. HOLD: end_rgb.
  - FLASH: end_rgb when phase = on, 3'b000 when phase = off.
  - Registered: 1 cycle latency from the rgb inputs, matched by the 1-cycle sync delay.
- Simultaneous events:
  - start_key and a game_over rising edge in the same cycle resolve by current state (only one is legal in any state).
  - A request arriving on the frame_tick cycle itself commits on the next tick.
- Widths: frm_cnt is 8 bits, blink_cnt is 4 bits; comparisons are against the parameters. No wrap is possible within the legal parameter ranges.
- Reset asserted mid-FLASH or mid-HOLD returns to START immediately. No pulse outputs fire.

Decomposition:
- Shared package holds: state encoding constants (ST_START=0, ST_GAME=1, ST_FLASH=2, ST_HOLD=3), RGB_W=3, and the parameter range limits.
- One natural sub-module: frame_tick_gen (Vsync falling-edge detector plus 1-cycle sync delay), reused by other screen blocks.
- FSM, counters and mux stay in screen_sequencer.

Test Plan:
Bench parameters: FLASH_FRAMES=2, FLASH_COUNT=2, HOLD_FRAMES=3; short synthetic frames of 100 cycles; rgb inputs start=3'b001, game=3'b010, end=3'b100.
1. Reset release, no keys -> screen_mode=0; the pins show 001 one cycle after the input; Hsync_sig/Vsync_sig equal the inputs delayed 1 cycle.
2. start_key mid-frame -> no change until the next Vsync falling edge; then mode=1, game_rst_pulse high exactly 1 cycle, pins 010.
3. game_over_sig rises in GAME -> at the next tick mode=2; pins follow the sequence on(2 frames), off 000 (2), on (2), off (2). Flash_over_sig pulses once; then mode=3 with pins 100.
4. HOLD with no key -> after 3 ticks mode=0. Repeat with start_key during HOLD frame 2 -> mode=1 at the next tick, game_rst_pulse fires, no START frame in between.
5. Ignored requests: start_key in GAME, and a game_over_sig rise while in START or during FLASH -> no state change and no pending latch. This is confirmed by a clean FLASH count afterwards.
6. RSTn low for 3 cycles mid-FLASH (off phase) -> all outputs at reset values asynchronously; after release mode=0 and Flash_over_sig is never seen.
